// File: rtl/seq_stack.sv
// Instruction sequencer: decodes one instruction per enabled cycle, drives the next
// address and output-register writes, with a hardware return stack and sticky error state.
module seq_stack #(
    parameter int unsigned AddrWidth   = 8,
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned CmdWidth    = 4,
    parameter int unsigned InRegCount  = 4,
    parameter int unsigned OutRegCount = 8,
    parameter int unsigned StackDepth  = 4,
    localparam int unsigned ISelW      = (InRegCount > 1) ? $clog2(InRegCount) : 1,
    localparam int unsigned OSelW      = (OutRegCount > 1) ? $clog2(OutRegCount) : 1,
    localparam int unsigned InstWidth  = 4 + 1 + OSelW + CmdWidth + DataWidth
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [InstWidth-1:0]             inst,
    input  logic                             inst_en,
    input  logic [InRegCount*DataWidth-1:0]  ireg,
    output logic [AddrWidth-1:0]             next,
    output logic [CmdWidth+DataWidth-1:0]    oreg,
    output logic [OutRegCount-1:0]           oreg_wen,
    output logic                             error
);

    localparam int unsigned SpW  = $clog2(StackDepth + 1);
    localparam int unsigned PtrW = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    localparam logic [3:0] OP_NO = 4'd0;
    localparam logic [3:0] OP_CI = 4'd1;
    localparam logic [3:0] OP_CR = 4'd2;
    localparam logic [3:0] OP_JI = 4'd3;
    localparam logic [3:0] OP_JR = 4'd4;
    localparam logic [3:0] OP_JZ = 4'd5;
    localparam logic [3:0] OP_JN = 4'd6;
    localparam logic [3:0] OP_CA = 4'd7;
    localparam logic [3:0] OP_RT = 4'd8;
    localparam logic [3:0] OP_WZ = 4'd9;

    typedef enum logic {
        RUN,
        ERROR
    } state_t;

    state_t                          state_q, state_d;
    logic [AddrWidth-1:0]            next_d, next_inc_c, addr_c;
    logic [CmdWidth+DataWidth-1:0]   oreg_d;
    logic [OutRegCount-1:0]          wen_d;
    logic [SpW-1:0]                  sp_q, sp_d;
    logic                            push_c;
    logic [AddrWidth-1:0]            stack_q [StackDepth];
    logic [3:0]                      op_c;
    logic [OSelW-1:0]                osel_c;
    logic [CmdWidth-1:0]             cmd_c;
    logic [DataWidth-1:0]            data_c;
    logic [ISelW-1:0]                isel_c;
    logic [DataWidth-1:0]            ireg_sel_c;

    assign op_c       = inst[InstWidth-1 -: 4];
    assign osel_c     = inst[DataWidth+CmdWidth +: OSelW];
    assign cmd_c      = inst[DataWidth +: CmdWidth];
    assign data_c     = inst[DataWidth-1:0];
    assign isel_c     = inst[ISelW-1:0];
    assign addr_c     = inst[InstWidth-5 -: AddrWidth];
    assign next_inc_c = AddrWidth'(next + 1'b1);

    // Input register mux; out-of-range selects read as zero
    always_comb begin
        ireg_sel_c = '0;
        for (int k = 0; k < int'(InRegCount); k++) begin
            if (isel_c == ISelW'(k)) ireg_sel_c = ireg[k*DataWidth +: DataWidth];
        end
    end

    // Next-state and decode; any fault freezes next/oreg/stack and enters ERROR
    always_comb begin
        state_d = state_q;
        next_d  = next;
        oreg_d  = oreg;
        wen_d   = '0;
        sp_d    = sp_q;
        push_c  = 1'b0;
        if (state_q == RUN && inst_en) begin
            next_d = next_inc_c;
            case (op_c)
                OP_NO: ;
                OP_CI: begin
                    oreg_d = {cmd_c, data_c};
                    wen_d  = OutRegCount'(1) << osel_c;
                end
                OP_CR: begin
                    oreg_d = {cmd_c, ireg_sel_c};
                    wen_d  = OutRegCount'(1) << osel_c;
                end
                OP_JI: next_d = addr_c;
                OP_JR: next_d = AddrWidth'(ireg_sel_c);
                OP_JZ: if (ireg_sel_c == '0) next_d = addr_c;
                OP_JN: if (ireg_sel_c != '0) next_d = addr_c;
                OP_CA: begin
                    if (sp_q == SpW'(StackDepth)) begin
                        state_d = ERROR;
                        next_d  = next;
                    end else begin
                        push_c = 1'b1;
                        sp_d   = SpW'(sp_q + 1'b1);
                        next_d = addr_c;
                    end
                end
                OP_RT: begin
                    if (sp_q == '0) begin
                        state_d = ERROR;
                        next_d  = next;
                    end else begin
                        sp_d   = SpW'(sp_q - 1'b1);
                        next_d = stack_q[PtrW'(sp_q - 1'b1)];
                    end
                end
                OP_WZ: if (ireg_sel_c == '0) next_d = next;
                default: begin
                    state_d = ERROR;
                    next_d  = next;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            next     <= '0;
            oreg     <= '0;
            oreg_wen <= '0;
            error    <= 1'b0;
            sp_q     <= '0;
        end else begin
            state_q  <= state_d;
            next     <= next_d;
            oreg     <= oreg_d;
            oreg_wen <= wen_d;
            error    <= (state_d == ERROR);
            sp_q     <= sp_d;
        end
    end

    // Return stack storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(StackDepth); i++) stack_q[i] <= '0;
        end else if (push_c) begin
            stack_q[PtrW'(sp_q)] <= next_inc_c;
        end
    end

endmodule
